// File: rtl/addergen_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : addergen_pipe                                             |
// | Function : pipelined add/subtract, one carry chunk resolved per      |
// |            stage, valid/ready handshake with a global stall          |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module addergen_pipe #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             ovf
);
    localparam int c_CW = WIDTH / STAGES;

    logic             w_stall;
    logic [WIDTH-1:0] w_bx;
    logic             w_cx;

    assign w_stall  = out_valid && !out_ready;
    assign in_ready = !w_stall;
    assign w_bx     = sub ? ~b : b;
    assign w_cx     = ci ^ sub;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // Each stage carries only the operand chunks not yet resolved and
        // the sum chunks already resolved, so no register bit is dead.
        localparam int c_IW = (STAGES - k) * c_CW;
        localparam int c_SW = (k + 1) * c_CW;

        logic [c_IW-1:0] w_a;
        logic [c_IW-1:0] w_b;
        logic            w_cin;
        logic            w_vin;
        logic [c_CW:0]   w_add;
        logic [c_SW-1:0] w_s;
        logic [c_SW-1:0] r_s;
        logic            r_c;
        logic            r_v;

        if (k == 0) begin : g_head
            assign w_a   = a;
            assign w_b   = w_bx;
            assign w_cin = w_cx;
            assign w_vin = in_valid && in_ready;
            assign w_s   = w_add[c_CW-1:0];
        end else begin : g_body
            assign w_a   = g_stage[k-1].g_skew.r_a;
            assign w_b   = g_stage[k-1].g_skew.r_b;
            assign w_cin = g_stage[k-1].r_c;
            assign w_vin = g_stage[k-1].r_v;
            assign w_s   = {w_add[c_CW-1:0], g_stage[k-1].r_s};
        end

        assign w_add = {1'b0, w_a[c_CW-1:0]} + {1'b0, w_b[c_CW-1:0]} + {{c_CW{1'b0}}, w_cin};

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_v <= 1'b0;
                r_c <= 1'b0;
                r_s <= '0;
            end else if (!w_stall) begin
                r_v <= w_vin;
                if (w_vin) begin
                    r_c <= w_add[c_CW];
                    r_s <= w_s;
                end
            end
        end

        if (k < STAGES - 1) begin : g_skew
            logic [c_IW-c_CW-1:0] r_a;
            logic [c_IW-c_CW-1:0] r_b;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (!w_stall && w_vin) begin
                    r_a <= w_a[c_IW-1:c_CW];
                    r_b <= w_b[c_IW-1:c_CW];
                end
            end
        end else begin : g_tail
            // Overflow is decided where the MSB chunk resolves.
            logic r_ovf;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_ovf <= 1'b0;
                end else if (!w_stall && w_vin) begin
                    r_ovf <= (w_a[c_CW-1] == w_b[c_CW-1]) && (w_add[c_CW-1] != w_a[c_CW-1]);
                end
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].r_v;
    assign sum       = g_stage[STAGES-1].r_s;
    assign co        = g_stage[STAGES-1].r_c;
    assign ovf       = g_stage[STAGES-1].g_tail.r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_addergen_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_addergen_pipe                                          |
// | Function : directed vectors, streaming, backpressure, reset and      |
// |            parameter sweep for addergen_pipe                         |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_addergen_pipe;
    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        co;
    logic        ovf;

    int nvec = 0;
    int nbad = 0;
    int n_acc;
    int n_emit;
    int sw_done_cnt = 0;
    logic [65:0] q[$];

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        ci;
        logic        sub;
        logic [15:0] s;
        logic        co;
        logic        ov;
    } vec_t;
    vec_t vt[12];

    addergen_pipe #(.WIDTH(16), .STAGES(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .ci(ci), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .co(co), .ovf(ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
        $fatal(1);
    end

    // Reference: {ovf, co, sum} with sum zero-extended to 64 bits.
    function automatic logic [65:0] model(input int w, input logic [63:0] x, input logic [63:0] y,
                                          input logic c, input logic s);
        logic [63:0] mask;
        logic [63:0] bx;
        logic [64:0] t;
        logic        cout;
        logic        ov;
        mask = (64'd1 << w) - 64'd1;
        bx   = (s ? ~y : y) & mask;
        t    = {1'b0, x & mask} + {1'b0, bx} + 65'(c ^ s);
        cout = t[w];
        ov   = (x[w-1] == bx[w-1]) && (t[w-1] != x[w-1]);
        return {ov, cout, t[63:0] & mask};
    endfunction

    task automatic check(input string nm, input logic [65:0] act, input logic [65:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    task automatic step_check();
        check("in_ready rule", 66'(in_ready), 66'(!(out_valid && !out_ready)));
        if (out_valid) begin
            if (q.size() == 0) begin
                nvec++;
                nbad++;
                $display("FAIL spurious beat: got sum %h with empty scoreboard, required none", sum);
            end else begin
                check("stream result", {ovf, co, 64'(sum)}, q[0]);
                if (out_ready) begin
                    void'(q.pop_front());
                    n_emit++;
                end
            end
        end
        if (in_valid && in_ready) begin
            q.push_back(model(16, 64'(a), 64'(b), ci, sub));
            n_acc++;
        end
    endtask

    task automatic run_traffic(input int ncyc, input int pin, input int pout);
        n_acc  = 0;
        n_emit = 0;
        for (int n = 0; n < ncyc; n++) begin
            @(negedge clk);
            out_ready = ($urandom_range(99) < pout);
            in_valid  = ($urandom_range(99) < pin);
            a   = 16'($urandom);
            b   = 16'($urandom);
            ci  = 1'($urandom);
            sub = 1'($urandom);
            #1 step_check();
        end
        for (int n = 0; n < 60 && q.size() > 0; n++) begin
            @(negedge clk);
            out_ready = 1'b1;
            in_valid  = 1'b0;
            #1 step_check();
        end
        check("scoreboard drained", 66'(q.size()), 66'd0);
        check("beats in == beats out", 66'(n_emit), 66'(n_acc));
    endtask

    task automatic wait_out(output int lat);
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin : p_main
        int lat;
        int stale;
        vt[0]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vt[1]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vt[2]  = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vt[3]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vt[4]  = '{16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0};
        vt[5]  = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
        vt[6]  = '{16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0};
        vt[7]  = '{16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000E, 1'b1, 1'b0};
        vt[8]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vt[9]  = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        vt[10] = '{16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0};
        vt[11] = '{16'h7FFF, 16'hFFFF, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; ci = 1'b0; sub = 1'b0;
        repeat (2) @(negedge clk);
        check("reset out_valid", 66'(out_valid), 66'd0);
        check("reset sum/co/ovf", {ovf, co, 64'(sum)}, 66'd0);
        check("reset in_ready", 66'(in_ready), 66'd1);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            a = vt[i].a; b = vt[i].b; ci = vt[i].ci; sub = vt[i].sub; in_valid = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            wait_out(lat);
            check($sformatf("vec%0d latency", i), 66'(lat), 66'd4);
            check($sformatf("vec%0d sum", i), 66'(sum), 66'(vt[i].s));
            check($sformatf("vec%0d co/ovf", i), {64'd0, co, ovf}, {64'd0, vt[i].co, vt[i].ov});
        end

        // Stall: result must hold and no new beat may enter.
        @(negedge clk);
        out_ready = 1'b0;
        a = 16'h1234; b = 16'h1111; ci = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        wait_out(lat);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a = 16'hAAAA; b = 16'h0001; in_valid = 1'b1;
            #1;
            check("stall in_ready", 66'(in_ready), 66'd0);
            check("stall hold", {ovf, co, 64'(sum)}, {2'b00, 64'h2345});
        end
        @(negedge clk);
        out_ready = 1'b1;
        lat = 0;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("post-stall latency", 66'(lat), 66'd4);
        check("post-stall result", {ovf, co, 64'(sum)}, {2'b00, 64'hAAAB});

        run_traffic(100, 100, 100);
        check("streaming beat count", 66'(n_acc), 66'd100);
        run_traffic(300, 60, 50);

        // Reset with the pipe full: output beat plus three in flight.
        @(negedge clk);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a = 16'(i * 3 + 1); b = 16'h0100; ci = 1'b0; sub = 1'b0; in_valid = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("pre-reset out_valid", 66'(out_valid), 66'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async reset out_valid", 66'(out_valid), 66'd0);
        check("async reset outputs", {ovf, co, 64'(sum)}, 66'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        a = 16'h1234; b = 16'h1111; ci = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        wait_out(lat);
        check("after reset latency", 66'(lat), 66'd4);
        check("after reset result", {ovf, co, 64'(sum)}, {2'b00, 64'h2345});
        stale = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        check("no stale beats", 66'(stale), 66'd0);

        for (int n = 0; n < 5000 && sw_done_cnt < 3; n++) @(negedge clk);
        check("sweep completion", 66'(sw_done_cnt), 66'd3);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

    localparam int c_SW_W[3] = '{8, 8, 32};
    localparam int c_SW_S[3] = '{1, 8, 4};

    for (genvar g = 0; g < 3; g++) begin : g_sweep
        localparam int W = c_SW_W[g];
        localparam int S = c_SW_S[g];
        logic         rn;
        logic         iv;
        logic         ir;
        logic         ov;
        logic         orr;
        logic         cin;
        logic         sb;
        logic         co_o;
        logic         ovf_o;
        logic [W-1:0] aa;
        logic [W-1:0] bb;
        logic [W-1:0] ss;

        addergen_pipe #(.WIDTH(W), .STAGES(S)) u_dut (
            .clk(clk), .rst_n(rn), .in_valid(iv), .in_ready(ir), .a(aa), .b(bb),
            .ci(cin), .sub(sb), .out_valid(ov), .out_ready(orr), .sum(ss),
            .co(co_o), .ovf(ovf_o)
        );

        initial begin : p_sweep
            logic [65:0] sq[$];
            logic [65:0] exp;
            int lat;
            rn = 1'b0; iv = 1'b0; orr = 1'b1; aa = '0; bb = '0; cin = 1'b0; sb = 1'b0;
            repeat (2) @(negedge clk);
            rn = 1'b1;
            aa = W'($urandom); bb = W'($urandom); cin = 1'b1; sb = 1'b1; iv = 1'b1;
            exp = model(W, 64'(aa), 64'(bb), cin, sb);
            @(negedge clk);
            iv = 1'b0;
            lat = 1;
            while (!ov && lat < 40) begin
                @(negedge clk);
                lat++;
            end
            check($sformatf("sweep W%0d S%0d latency", W, S), 66'(lat), 66'(S));
            check($sformatf("sweep W%0d S%0d probe", W, S), {ovf_o, co_o, 64'(ss)}, exp);
            @(negedge clk);
            for (int n = 0; n < 400; n++) begin
                if (n < 300) begin
                    orr = ($urandom_range(99) < 70);
                    iv  = ($urandom_range(99) < 70);
                end else begin
                    orr = 1'b1;
                    iv  = 1'b0;
                end
                aa = W'($urandom); bb = W'($urandom); cin = 1'($urandom); sb = 1'($urandom);
                #1;
                if (ov) begin
                    if (sq.size() == 0) begin
                        nvec++;
                        nbad++;
                        $display("FAIL sweep W%0d S%0d spurious beat: got %h, required none", W, S, ss);
                    end else begin
                        check($sformatf("sweep W%0d S%0d data", W, S), {ovf_o, co_o, 64'(ss)}, sq[0]);
                        if (orr) void'(sq.pop_front());
                    end
                end
                if (iv && ir) sq.push_back(model(W, 64'(aa), 64'(bb), cin, sb));
                @(negedge clk);
            end
            check($sformatf("sweep W%0d S%0d drained", W, S), 66'(sq.size()), 66'd0);
            sw_done_cnt++;
        end
    end

endmodule
`default_nettype wire
